// File: rtl/cache_pkg.sv
// ----------------------------------------------------------------------------
// cache_pkg
// Shared constants, address slicing helpers and FSM state type for the
// 2-way set-associative write-through read cache.
//   BASE_ADDR  : data-memory base, subtracted from the byte address
//   IDX_W      : set index width (64 sets)
//   TAG_W      : tag width
//   *_LSB/*_MSB: bit positions of index and tag inside the offset
// ----------------------------------------------------------------------------
package cache_pkg;

    localparam int unsigned BASE_ADDR = 1024;
    localparam int unsigned IDX_W     = 6;
    localparam int unsigned TAG_W     = 11;

    localparam int unsigned IDX_LSB   = 2;
    localparam int unsigned IDX_MSB   = IDX_LSB + IDX_W - 1;
    localparam int unsigned TAG_LSB   = IDX_MSB + 1;
    localparam int unsigned TAG_MSB   = TAG_LSB + TAG_W - 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RMISS = 2'd1,
        WRITE = 2'd2
    } state_t;

    function automatic logic [IDX_W-1:0] off_index(input logic [31:0] off);
        return off[IDX_MSB:IDX_LSB];
    endfunction

    function automatic logic [TAG_W-1:0] off_tag(input logic [31:0] off);
        return off[TAG_MSB:TAG_LSB];
    endfunction

endpackage

// File: rtl/cache_mem.sv
// ----------------------------------------------------------------------------
// cache_mem
// Storage for the 2-way cache: per-way valid/tag/data arrays and a per-set
// LRU bit (the way to replace next). Lookup is combinational on index/tag;
// fills and data updates are written on the rising clock edge. Valid and LRU
// bits are cleared asynchronously by rst (active low); tag/data are not reset
// because a cleared valid bit masks them.
// Ports:
//   clk, rst          : clock, async active-low clear of valid/LRU
//   index, tag        : lookup (and write) set index and tag
//   hit, hit_way      : lookup result; way0 preferred if both match
//   hit_data          : data word of the hitting way
//   valid_at, lru_at  : valid bits and LRU bit of the indexed set
//   fill_en           : write valid+tag+data into 'way'
//   upd_en            : write data only into 'way' (write hit)
//   lru_en            : point LRU of the set at the way opposite to 'way'
//   way, wr_data      : target way and word for fill/update
// ----------------------------------------------------------------------------
module cache_mem
    import cache_pkg::*;
#(
    parameter int unsigned SETS = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] index,
    input  logic [TAG_W-1:0] tag,
    output logic             hit,
    output logic             hit_way,
    output logic [31:0]      hit_data,
    output logic [1:0]       valid_at,
    output logic             lru_at,
    input  logic             fill_en,
    input  logic             upd_en,
    input  logic             lru_en,
    input  logic             way,
    input  logic [31:0]      wr_data
);

    logic        way_hit   [2];
    logic        way_valid [2];
    logic [31:0] way_data  [2];
    logic [SETS-1:0] lru_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_way
            logic [SETS-1:0]  valid_reg;
            logic [TAG_W-1:0] tag_reg  [SETS];
            logic [31:0]      data_reg [SETS];
            logic             sel;

            assign sel = (way == 1'(gi));

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    valid_reg <= '0;
                end else if (fill_en && sel) begin
                    valid_reg[index] <= 1'b1;
                end
            end

            always_ff @(posedge clk) begin
                if (fill_en && sel) begin
                    tag_reg[index] <= tag;
                end
                if ((fill_en || upd_en) && sel) begin
                    data_reg[index] <= wr_data;
                end
            end

            assign way_valid[gi] = valid_reg[index];
            assign way_hit[gi]   = valid_reg[index] && (tag_reg[index] == tag);
            assign way_data[gi]  = data_reg[index];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lru_reg <= '0;
        end else if (lru_en) begin
            lru_reg[index] <= ~way;
        end
    end

    assign hit      = way_hit[0] || way_hit[1];
    assign hit_way  = !way_hit[0];
    assign hit_data = way_hit[0] ? way_data[0] : way_data[1];
    assign valid_at = {way_valid[1], way_valid[0]};
    assign lru_at   = lru_reg[index];

endmodule

// File: rtl/cache_controller.sv
// ----------------------------------------------------------------------------
// cache_controller
// 2-way set-associative write-through read cache between the MEM stage and
// the SRAM controller. Read hits complete in the same cycle; read misses
// fetch through the SRAM read handshake and fill a victim way; all writes go
// to SRAM (hitting lines updated in place, no allocation on write miss).
// Ports:
//   clk, rst               : clock, async active-low reset
//   mem_r_en, mem_w_en     : MEM-stage requests, held until ready=1
//   address, wdata         : byte address (>= BASE_ADDR), write data
//   rdata, ready           : read data, 0 = stall pipeline
//   sram_r_en, sram_w_en   : requests to the SRAM controller
//   sram_address/wdata     : pass-through of address/wdata
//   sram_rdata, sram_ready : SRAM read word and completion flag
// ----------------------------------------------------------------------------
module cache_controller
    import cache_pkg::*;
#(
    parameter int unsigned BASE_ADDR = cache_pkg::BASE_ADDR,
    parameter int unsigned SETS      = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_r_en,
    input  logic        mem_w_en,
    input  logic [31:0] address,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        sram_r_en,
    output logic        sram_w_en,
    output logic [31:0] sram_address,
    output logic [31:0] sram_wdata,
    input  logic [31:0] sram_rdata,
    input  logic        sram_ready
);

    state_t state_reg, state_next;

    logic [31:0]      off;
    logic [IDX_W-1:0] index;
    logic [TAG_W-1:0] tag;

    logic        hit, hit_way, lru_at;
    logic [31:0] hit_data;
    logic [1:0]  valid_at;
    logic        victim;
    logic        fill_en, upd_en, lru_en, wr_way;
    logic [31:0] wr_data;

    assign off   = address - 32'(BASE_ADDR);
    assign index = off_index(off);
    assign tag   = off_tag(off);

    assign sram_address = address;
    assign sram_wdata   = wdata;

    // Victim: first invalid way (way0 first), otherwise the LRU way.
    assign victim = !valid_at[0] ? 1'b0 :
                    !valid_at[1] ? 1'b1 : lru_at;

    cache_mem #(
        .SETS(SETS)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .index   (index),
        .tag     (tag),
        .hit     (hit),
        .hit_way (hit_way),
        .hit_data(hit_data),
        .valid_at(valid_at),
        .lru_at  (lru_at),
        .fill_en (fill_en),
        .upd_en  (upd_en),
        .lru_en  (lru_en),
        .way     (wr_way),
        .wr_data (wr_data)
    );

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; a simultaneous read and write takes the write path.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (mem_w_en) begin
                    state_next = WRITE;
                end else if (mem_r_en && !hit) begin
                    state_next = RMISS;
                end
            end
            RMISS: if (sram_ready) state_next = IDLE;
            WRITE: if (sram_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output and array-control decode
    always_comb begin
        ready     = 1'b1;
        rdata     = '0;
        sram_r_en = 1'b0;
        sram_w_en = 1'b0;
        fill_en   = 1'b0;
        upd_en    = 1'b0;
        lru_en    = 1'b0;
        wr_way    = hit_way;
        wr_data   = wdata;
        case (state_reg)
            IDLE: begin
                if (mem_w_en) begin
                    // The write is issued from WRITE, but a hitting line is
                    // refreshed now since address/wdata are already stable.
                    ready  = 1'b0;
                    upd_en = hit;
                    lru_en = hit;
                end else if (mem_r_en) begin
                    ready  = hit;
                    rdata  = hit ? hit_data : '0;
                    lru_en = hit;
                end
            end
            RMISS: begin
                sram_r_en = 1'b1;
                ready     = sram_ready;
                rdata     = sram_ready ? sram_rdata : '0;
                fill_en   = sram_ready;
                lru_en    = sram_ready;
                wr_way    = victim;
                wr_data   = sram_rdata;
            end
            WRITE: begin
                sram_w_en = 1'b1;
                ready     = sram_ready;
            end
            default: begin
                ready = 1'b1;
            end
        endcase
        // Outputs forced to their idle values while reset is held.
        if (!rst) begin
            ready     = 1'b1;
            rdata     = '0;
            sram_r_en = 1'b0;
            sram_w_en = 1'b0;
            fill_en   = 1'b0;
            upd_en    = 1'b0;
            lru_en    = 1'b0;
        end
    end

endmodule

// File: tb/tb_cache_controller.sv
// ----------------------------------------------------------------------------
// tb_cache_controller
// Table-driven bench for cache_controller with a 6-cycle SRAM model and a
// scoreboard queue of expected transaction results.
// ----------------------------------------------------------------------------
module tb_cache_controller;

    localparam int LAT     = 6;
    localparam int TIMEOUT = 40;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_r_en, mem_w_en;
    logic [31:0] address, wdata;
    logic [31:0] rdata;
    logic        ready;
    logic        sram_r_en, sram_w_en;
    logic [31:0] sram_address, sram_wdata, sram_rdata;
    logic        sram_ready;

    always #5 clk = ~clk;

    cache_controller dut (
        .clk         (clk),
        .rst         (rst),
        .mem_r_en    (mem_r_en),
        .mem_w_en    (mem_w_en),
        .address     (address),
        .wdata       (wdata),
        .rdata       (rdata),
        .ready       (ready),
        .sram_r_en   (sram_r_en),
        .sram_w_en   (sram_w_en),
        .sram_address(sram_address),
        .sram_wdata  (sram_wdata),
        .sram_rdata  (sram_rdata),
        .sram_ready  (sram_ready)
    );

    // ---------------- SRAM controller model ----------------
    int          sram_cnt = 0;
    bit [1023:0] written;
    logic [31:0] wmem [1024];

    function automatic logic [31:0] init_word(input logic [31:0] a);
        case (a)
            32'h400: return 32'hDEADBEEF;
            32'h500: return 32'h11111111;
            32'h600: return 32'h22222222;
            32'h700: return 32'h33333333;
            32'h404: return 32'hCAFEF00D;
            32'h408: return 32'h55555555;
            default: return 32'h0;
        endcase
    endfunction

    assign sram_ready = !(sram_r_en || sram_w_en) || (sram_cnt == LAT);
    assign sram_rdata = written[sram_address[11:2]] ? wmem[sram_address[11:2]]
                                                    : init_word(sram_address);

    always @(posedge clk) begin
        if ((sram_r_en || sram_w_en) && !sram_ready) sram_cnt <= sram_cnt + 1;
        else                                         sram_cnt <= 0;
        if (sram_w_en && sram_ready) begin
            wmem[sram_address[11:2]]    <= sram_wdata;
            written[sram_address[11:2]] <= 1'b1;
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        logic        r;
        logic        w;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] exp_rdata;
        int          exp_stall;
        logic        exp_srd;
        logic        exp_swr;
    } vec_t;

    vec_t vecs [15];
    vec_t sb_q [$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   n_txn = 0;

    function automatic vec_t mk(input logic r, input logic w, input logic [31:0] a,
                                input logic [31:0] wd, input logic [31:0] er,
                                input int st, input logic srd, input logic swr);
        vec_t v;
        v.r = r; v.w = w; v.addr = a; v.wd = wd; v.exp_rdata = er;
        v.exp_stall = st; v.exp_srd = srd; v.exp_swr = swr;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the transaction ends.
    task automatic run_access(input vec_t v);
        int          stall;
        logic        saw_r, saw_w, done, timed_out;
        logic [31:0] got;
        vec_t        e;
        sb_q.push_back(v);
        mem_r_en = v.r; mem_w_en = v.w; address = v.addr; wdata = v.wd;
        stall = 0; saw_r = 0; saw_w = 0; done = 0; timed_out = 0; got = '0;
        while (!done) begin
            @(negedge clk);
            saw_r |= sram_r_en;
            saw_w |= sram_w_en;
            if (ready) begin
                got  = rdata;
                done = 1;
            end else begin
                stall++;
                if (stall > TIMEOUT) begin
                    timed_out = 1;
                    done      = 1;
                end else begin
                    @(posedge clk);
                    #1;
                end
            end
        end
        e = sb_q.pop_front();
        n_txn++;
        $display("txn %0d r=%0b w=%0b addr=%h rdata=%h stall=%0d srd=%0b swr=%0b",
                 n_txn, v.r, v.w, v.addr, got, stall, saw_r, saw_w);
        n_cmp++;
        if (timed_out) begin
            n_err++;
            $display("FAIL timeout txn %0d: ready stayed 0 for %0d cycles, required within %0d",
                     n_txn, stall, e.exp_stall);
        end
        check("stall_cycles", 32'(stall), 32'(e.exp_stall));
        check("sram_r_en_seen", 32'(saw_r), 32'(e.exp_srd));
        check("sram_w_en_seen", 32'(saw_w), 32'(e.exp_swr));
        if (e.r && !e.w) check("rdata", got, e.exp_rdata);
        @(posedge clk);
        #1;
        mem_r_en = 1'b0;
        mem_w_en = 1'b0;
    endtask

    initial begin
        vec_t rv;

        // Set 0 holds tags of 0x400/0x500/0x600/0x800; 0x404/0x408 are other sets.
        vecs[0]  = mk(1, 0, 32'h400, 0,            32'hDEADBEEF, 7, 1, 0);
        vecs[1]  = mk(1, 0, 32'h400, 0,            32'hDEADBEEF, 0, 0, 0);
        vecs[2]  = mk(1, 0, 32'h500, 0,            32'h11111111, 7, 1, 0);
        vecs[3]  = mk(1, 0, 32'h600, 0,            32'h22222222, 7, 1, 0);
        vecs[4]  = mk(1, 0, 32'h400, 0,            32'hDEADBEEF, 7, 1, 0);
        vecs[5]  = mk(1, 0, 32'h600, 0,            32'h22222222, 0, 0, 0);
        vecs[6]  = mk(1, 0, 32'h500, 0,            32'h11111111, 7, 1, 0);
        vecs[7]  = mk(1, 0, 32'h600, 0,            32'h22222222, 0, 0, 0);
        vecs[8]  = mk(1, 0, 32'h404, 0,            32'hCAFEF00D, 7, 1, 0);
        vecs[9]  = mk(0, 1, 32'h404, 32'h12345678, 0,            7, 0, 1);
        vecs[10] = mk(1, 0, 32'h404, 0,            32'h12345678, 0, 0, 0);
        vecs[11] = mk(0, 1, 32'h800, 32'hA5A5A5A5, 0,            7, 0, 1);
        vecs[12] = mk(1, 0, 32'h800, 0,            32'hA5A5A5A5, 7, 1, 0);
        vecs[13] = mk(1, 1, 32'h408, 32'h0BADCAFE, 0,            7, 0, 1);
        vecs[14] = mk(1, 0, 32'h408, 0,            32'h0BADCAFE, 7, 1, 0);

        // Reset with a pending (missing) read: outputs must stay idle.
        rst = 1'b0; mem_r_en = 1'b1; mem_w_en = 1'b0; address = 32'h400; wdata = '0;
        repeat (3) @(negedge clk);
        check("reset_ready", 32'(ready), 32'd1);
        check("reset_rdata", rdata, 32'd0);
        check("reset_sram_r_en", 32'(sram_r_en), 32'd0);
        check("reset_sram_w_en", 32'(sram_w_en), 32'd0);
        mem_r_en = 1'b0;
        #2 rst = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 15; i++) begin
            run_access(vecs[i]);
        end

        // Reset in the middle of a read miss.
        mem_r_en = 1'b1; address = 32'h700;
        repeat (4) @(negedge clk);
        check("midmiss_sram_r_en_before", 32'(sram_r_en), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("midmiss_sram_r_en", 32'(sram_r_en), 32'd0);
        check("midmiss_ready", 32'(ready), 32'd1);
        check("midmiss_rdata", rdata, 32'd0);
        @(negedge clk);
        mem_r_en = 1'b0;
        #2 rst = 1'b1;
        @(posedge clk);
        #1;
        // 0x404 was cached before reset and its SRAM copy holds the written word.
        rv = mk(1, 0, 32'h404, 0, 32'h12345678, 7, 1, 0);
        run_access(rv);
        rv = mk(1, 0, 32'h404, 0, 32'h12345678, 0, 0, 0);
        run_access(rv);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
